// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci checker and its generator.
package fib_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fib_checker_if.sv
// Term stream from a Fibonacci producer into the checker.
// Handshake: a beat transfers on a posedge where in_valid and in_ready are both 1;
// in_data is meaningful only when in_valid=1, and in_ready never depends on in_valid.
interface fib_checker_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fib_step.sv
// Expected-term generator: holds the last two Fibonacci terms, WIDTH-bit wrapping.
module fib_step #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] exp_cur
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] exp_prev;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      exp_prev <= '0;
      exp_cur  <= ONE;
    end else if (advance) begin
      exp_prev <= exp_cur;
      exp_cur  <= exp_cur + exp_prev;
    end
  end

endmodule

// File: rtl/fib_checker.sv
// Consumes up to n Fibonacci terms and reports pass/fail with first-mismatch details.
module fib_checker
  import fib_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n,
  fib_checker_if.slave     s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] err_index,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_actual,
  output state_t           state_dbg
);

  state_t           state;
  logic [CNT_W-1:0] n_q;
  logic             ready_q;
  logic [WIDTH-1:0] exp_cur;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             match;
  logic             load;
  logic             advance;

  assign s.in_ready = ready_q;
  assign state_dbg  = state;

  always_comb begin
    cnt_nxt = count + 1'b1;
    accept  = s.in_valid && ready_q;
    match   = (s.in_data == exp_cur);
    load    = start && (state != CHECK);
    advance = accept && match;
  end

  fib_step #(.WIDTH(WIDTH)) u_step (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .exp_cur (exp_cur)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n_q          <= '0;
      ready_q      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      count        <= '0;
      err_index    <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_q          <= n;
            count        <= '0;
            err_index    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            // An empty run completes immediately as a pass.
            if (n == '0) begin
              state   <= DONE;
              ready_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end else begin
              state   <= CHECK;
              ready_q <= 1'b1;
              busy    <= 1'b1;
              done    <= 1'b0;
              pass    <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            count <= cnt_nxt;
            if (!match) begin
              err_index    <= cnt_nxt;
              err_expected <= exp_cur;
              err_actual   <= s.in_data;
              state        <= DONE;
              ready_q      <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              pass         <= 1'b0;
            end else if (cnt_nxt == n_q) begin
              state   <= DONE;
              ready_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fib_checker.md
Name: fib_checker

Overview:
- Stream consumer and verifier for Fibonacci sequences. It is the receiving end of the team's Fibonacci generator output.
- Accepts up to n terms over a valid/ready handshake and compares each against an internally generated expected term (1, 1, 2, 3, 5, ...).
- Reports pass/fail plus first-mismatch details.
- Used in self-checking benches and as a BIST sink behind the generator.

Parameters:
- WIDTH, 32, data width of each term; all arithmetic is modulo 2^WIDTH.
- CNT_W, 6, width of the term count, n, and index fields (max n = 2^CNT_W - 1).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; latches n and begins a check run.
- n  input  CNT_W  number of terms to check; sampled only on an accepted start.
- in_valid  input  1  producer has a term on in_data.
- in_data  input  WIDTH  term value.
- in_ready  output  1  checker can accept a term this cycle.
- busy  output  1  run in progress (state CHECK).
- done  output  1  run finished; held until the next accepted start or rst.
- pass  output  1  valid when done=1: all n terms matched.
- count  output  CNT_W  number of terms accepted in the current or last run.
- err_index  output  CNT_W  1-based index of the first mismatching term.
- err_expected  output  WIDTH  expected value at err_index.
- err_actual  output  WIDTH  received value at err_index.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - in_ready=0, busy=0, done=0, pass=0, count=0.
  - err_index=0, err_expected=0, err_actual=0.
  - Internal exp_prev=0, exp_cur=1.
  - rst has priority over all other inputs in every state, including mid-run; a partial run is discarded.
- States: IDLE, CHECK, DONE. All outputs are registered.
- IDLE:
  - in_ready=0.
  - On start: latch n_q=n, clear count and err_* fields, set exp_prev=0 and exp_cur=1, clear done and pass.
  - If n==0, go to DONE with pass=1. Otherwise go to CHECK.
- CHECK:
  - in_ready=1 and busy=1.
  - A beat is accepted when in_valid & in_ready at a posedge; in_data is ignored otherwise.
  - On an accepted beat where in_data == exp_cur:
    - count <= count+1.
    - exp_prev <= exp_cur and exp_cur <= exp_cur + exp_prev, with a WIDTH-bit wrapping add.
    - If count+1 == n_q, go to DONE with pass=1.
  - On an accepted beat where in_data != exp_cur:
    - count <= count+1, err_index <= count+1, err_expected <= exp_cur, err_actual <= in_data.
    - Go to DONE with pass=0. The run stops at the first mismatch.
  - start is ignored while in CHECK.
  - Gaps with in_valid=0 are legal; the state holds.
- DONE:
  - done=1, busy=0, in_ready=0. pass, count and err_* hold.
  - start behaves as it does in IDLE and restarts directly.
- Latency:
  - in_ready rises the cycle after start.
  - done and pass rise the cycle after the final (or failing) handshake.
  - in_ready is low in the same cycle done rises, so at most n beats are ever accepted.
- Width rules:
  - Expected terms wrap modulo 2^WIDTH, matching a WIDTH-bit generator.
  - count never exceeds n_q, so the counter cannot wrap.

Decomposition:
- Package fib_pkg holds:
  - state typedef enum {IDLE, CHECK, DONE};
  - default WIDTH and CNT_W constants.
- Sub-module fib_step owns the expected-term generation:
  - registers exp_prev and exp_cur;
  - inputs load and advance;
  - output exp_cur.
  - It is reusable by the generator.
- The FSM, handshake and error capture stay in fib_checker.

Test Plan:
- n=5, start, stream 1,1,2,3,5 back-to-back -> in_ready high 5 cycles; done=1, pass=1, count=5 one cycle after the 5th beat; err_index=0.
- n=6, stream 1,1,2,4 -> after the 4th beat done=1, pass=0, count=4, err_index=4, err_expected=3, err_actual=4; in_ready=0 thereafter, further in_valid ignored.
- n=5, correct stream with in_valid gaps of 0-3 random cycles, plus a start pulse mid-run -> pass=1, count=5, start ignored, no extra beats accepted.
- n=0, start -> next cycle done=1, pass=1, count=0; in_ready never rises.
- n=48, WIDTH=32, correct wrapped stream -> term 47 = 2971215073 and term 48 = 512559680 (wrapped) both match; pass=1.
- n=5, 3 correct beats, then rst=1 for one cycle -> all outputs return to reset values; then start with n=2 and stream 1,1 -> pass=1, count=2.
